// File: rtl/layer_pkg.sv
// Shared definitions for the streaming layer blocks: default word width
// and the signed word type carried between layers.
package layer_pkg;

    localparam int WORD_SIZE = 16;

    typedef logic signed [WORD_SIZE-1:0] word_t;

endpackage : layer_pkg

// File: rtl/fork_fifo.sv
// Per-lane FIFO for the fork. Extra pointer bit distinguishes full from
// empty when the address bits coincide. Head word comes straight out of
// the storage array, so it stays put while the consumer stalls.
module fork_fifo #(
    parameter int WORD_SIZE = layer_pkg::WORD_SIZE,
    parameter int DEPTH     = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        push_i,
    input  logic signed [WORD_SIZE-1:0] data_i,
    output logic                        full_o,
    input  logic                        pop_i,
    output logic                        empty_o,
    output logic signed [WORD_SIZE-1:0] data_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic signed [WORD_SIZE-1:0] mem [DEPTH];
    logic [AW:0]                 wr_ptr;
    logic [AW:0]                 rd_ptr;

    // Storage and pointers; reset clears contents so the head reads zero.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_i) begin
                mem[wr_ptr[AW-1:0]] <= data_i;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (pop_i) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Status flags and head word, all derived from registered state.
    always_comb begin
        full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty_o = (wr_ptr == rd_ptr);
        data_o  = mem[rd_ptr[AW-1:0]];
    end

endmodule : fork_fifo

// File: rtl/fork_layer.sv
// Duplicates one signed stream onto two lanes, each with its own FIFO so
// the two consumers can stall independently.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high that cycle. Upstream: accept = valid_i & ready_o,
// and ready_o depends only on the FIFO registers (never on ready_i). Lane k
// downstream: pop = valid_o[k] & ready_i[k]; the head word is held stable
// while valid_o[k] is high and ready_i[k] is low.
module fork_layer #(
    parameter int WORD_SIZE = layer_pkg::WORD_SIZE,
    parameter int DEPTH     = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    input  logic signed [WORD_SIZE-1:0] data_r_i,
    output logic [1:0]                  valid_o,
    input  logic [1:0]                  ready_i,
    output logic signed [WORD_SIZE-1:0] data1_r_o,
    output logic signed [WORD_SIZE-1:0] data2_r_o
);

    logic full1;
    logic full2;
    logic empty1;
    logic empty2;
    logic accept;
    logic pop1;
    logic pop2;

    // A word is taken only when both lanes have room, so both FIFOs always
    // receive it on the same edge.
    always_comb begin
        ready_o = !full1 && !full2;
        accept  = valid_i && ready_o;
        valid_o = {!empty2, !empty1};
        pop1    = valid_o[0] && ready_i[0];
        pop2    = valid_o[1] && ready_i[1];
    end

    fork_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_lane1 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (accept),
        .data_i    (data_r_i),
        .full_o    (full1),
        .pop_i     (pop1),
        .empty_o   (empty1),
        .data_o    (data1_r_o)
    );

    fork_fifo #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_lane2 (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .push_i    (accept),
        .data_i    (data_r_i),
        .full_o    (full2),
        .pop_i     (pop2),
        .empty_o   (empty2),
        .data_o    (data2_r_o)
    );

endmodule : fork_layer

// File: tb/tb_fork_layer.sv
// Directed and randomised checks for fork_layer with DEPTH = 2.
module tb_fork_layer;

    localparam int W     = 16;
    localparam int DEPTH = 2;

    logic                clk;
    logic                reset_n;
    logic                valid_i;
    logic                ready_o;
    logic signed [W-1:0] data_r_i;
    logic [1:0]          valid_o;
    logic [1:0]          ready_i;
    logic signed [W-1:0] data1_r_o;
    logic signed [W-1:0] data2_r_o;

    int n_checks;
    int n_fail;

    logic [W-1:0] exp1_q[$];
    logic [W-1:0] exp2_q[$];

    fork_layer #(
        .WORD_SIZE (W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .data_r_i  (data_r_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .data1_r_o (data1_r_o),
        .data2_r_o (data2_r_o)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are changed and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Power-on reset state
        n_checks++;
        if (valid_o !== 2'b00 || ready_o !== 1'b1 || data1_r_o !== 16'h0000 || data2_r_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state: valid_o=%b ready_o=%b d1=%h d2=%h, want 00 1 0000 0000",
                     valid_o, ready_o, data1_r_o, data2_r_o);
        end
        tick();
        reset_n = 1'b1;
        // Buffer two words with both lanes stalled
        ready_i  = 2'b00;
        valid_i  = 1'b1;
        data_r_i = 16'h0698;
        tick();
        data_r_i = 16'hF8DD;
        tick();
        valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 2'b11 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_prefill: valid_o=%b ready_o=%b, want 11 0", valid_o, ready_o);
        end
        // Asynchronous reset in mid-cycle
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (valid_o !== 2'b00 || ready_o !== 1'b1 || data1_r_o !== 16'h0000 || data2_r_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_async: valid_o=%b ready_o=%b d1=%h d2=%h, want 00 1 0000 0000",
                     valid_o, ready_o, data1_r_o, data2_r_o);
        end
        tick();
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (valid_o !== 2'b00 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: valid_o=%b ready_o=%b, want 00 1", valid_o, ready_o);
        end
    endtask

    task automatic test_stream();
        logic [W-1:0] words [3];
        words[0] = 16'h0698;
        words[1] = 16'hF8DD;
        words[2] = 16'hF31C;
        ready_i  = 2'b11;
        valid_i  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_r_i = words[i];
            n_checks++;
            if (ready_o !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_ready[%0d]: ready_o=%b, want 1", i, ready_o);
            end
            tick();
            n_checks++;
            if (valid_o !== 2'b11 || data1_r_o !== words[i] || data2_r_o !== words[i]) begin
                n_fail++;
                $display("FAIL stream_word[%0d]: valid_o=%b d1=%h d2=%h, want 11 %h %h",
                         i, valid_o, data1_r_o, data2_r_o, words[i], words[i]);
            end
        end
        valid_i = 1'b0;
        tick();
        n_checks++;
        if (valid_o !== 2'b00 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_drained: valid_o=%b ready_o=%b, want 00 1", valid_o, ready_o);
        end
    endtask

    task automatic test_lane2_stall();
        ready_i  = 2'b01;
        valid_i  = 1'b1;
        data_r_i = 16'h1111;
        tick();                       // a accepted
        n_checks++;
        if (valid_o !== 2'b11 || data1_r_o !== 16'h1111 || data2_r_o !== 16'h1111 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_first: valid_o=%b d1=%h d2=%h ready_o=%b, want 11 1111 1111 1",
                     valid_o, data1_r_o, data2_r_o, ready_o);
        end
        data_r_i = 16'h2222;
        tick();                       // b accepted, lane 1 pops a
        n_checks++;
        if (valid_o !== 2'b11 || data1_r_o !== 16'h2222 || data2_r_o !== 16'h1111 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_full: valid_o=%b d1=%h d2=%h ready_o=%b, want 11 2222 1111 0",
                     valid_o, data1_r_o, data2_r_o, ready_o);
        end
        data_r_i = 16'h3333;
        tick();                       // c refused, lane 1 pops b
        tick();
        n_checks++;
        if (valid_o !== 2'b10 || data2_r_o !== 16'h1111 || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_wait: valid_o=%b d2=%h ready_o=%b, want 10 1111 0",
                     valid_o, data2_r_o, ready_o);
        end
        ready_i = 2'b11;
        tick();                       // lane 2 pops a
        n_checks++;
        if (valid_o !== 2'b10 || data2_r_o !== 16'h2222 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: valid_o=%b d2=%h ready_o=%b, want 10 2222 1",
                     valid_o, data2_r_o, ready_o);
        end
        tick();                       // c accepted, lane 2 pops b
        valid_i = 1'b0;
        n_checks++;
        if (valid_o !== 2'b11 || data1_r_o !== 16'h3333 || data2_r_o !== 16'h3333) begin
            n_fail++;
            $display("FAIL stall_third: valid_o=%b d1=%h d2=%h, want 11 3333 3333",
                     valid_o, data1_r_o, data2_r_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 2'b00 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_drained: valid_o=%b ready_o=%b, want 00 1", valid_o, ready_o);
        end
    endtask

    task automatic test_both_stalled();
        logic [W-1:0] words [4];
        int           accepted;
        words[0] = 16'h0698;
        words[1] = 16'h1234;
        words[2] = 16'h5555;
        words[3] = 16'h5555;
        accepted = 0;
        ready_i  = 2'b00;
        valid_i  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_r_i = words[accepted];
            if (ready_o === 1'b1) accepted++;
            tick();
        end
        n_checks++;
        if (accepted != DEPTH || ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL both_stall_count: accepted=%0d ready_o=%b, want %0d 0", accepted, ready_o, DEPTH);
        end
        n_checks++;
        if (valid_o !== 2'b11 || data1_r_o !== 16'h0698 || data2_r_o !== 16'h0698) begin
            n_fail++;
            $display("FAIL both_stall_hold: valid_o=%b d1=%h d2=%h, want 11 0698 0698",
                     valid_o, data1_r_o, data2_r_o);
        end
        valid_i = 1'b0;
        ready_i = 2'b11;
        tick();
        n_checks++;
        if (valid_o !== 2'b11 || data1_r_o !== 16'h1234 || data2_r_o !== 16'h1234) begin
            n_fail++;
            $display("FAIL both_stall_second: valid_o=%b d1=%h d2=%h, want 11 1234 1234",
                     valid_o, data1_r_o, data2_r_o);
        end
        tick();
        n_checks++;
        if (valid_o !== 2'b00 || ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL both_stall_drained: valid_o=%b ready_o=%b, want 00 1", valid_o, ready_o);
        end
    endtask

    // One cycle of the randomised run: check outputs against the queues,
    // then advance the edge and update the queues from the pre-edge handshake.
    task automatic random_cycle(input logic [1:0] rdy, input logic v, input logic [W-1:0] d, input int c);
        logic exp_ready;
        logic acc;
        logic pop1;
        logic pop2;
        ready_i   = rdy;
        valid_i   = v;
        data_r_i  = d;
        exp_ready = (exp1_q.size() < DEPTH) && (exp2_q.size() < DEPTH);
        n_checks++;
        if (ready_o !== exp_ready) begin
            n_fail++;
            $display("FAIL rand_ready c=%0d: ready_o=%b, want %b", c, ready_o, exp_ready);
        end
        n_checks++;
        if (valid_o !== {exp2_q.size() != 0, exp1_q.size() != 0}) begin
            n_fail++;
            $display("FAIL rand_valid c=%0d: valid_o=%b, want %b%b", c, valid_o,
                     exp2_q.size() != 0, exp1_q.size() != 0);
        end
        if (exp1_q.size() != 0) begin
            n_checks++;
            if (data1_r_o !== exp1_q[0]) begin
                n_fail++;
                $display("FAIL rand_data1 c=%0d: d1=%h, want %h", c, data1_r_o, exp1_q[0]);
            end
        end
        if (exp2_q.size() != 0) begin
            n_checks++;
            if (data2_r_o !== exp2_q[0]) begin
                n_fail++;
                $display("FAIL rand_data2 c=%0d: d2=%h, want %h", c, data2_r_o, exp2_q[0]);
            end
        end
        acc  = v && exp_ready;
        pop1 = (exp1_q.size() != 0) && rdy[0];
        pop2 = (exp2_q.size() != 0) && rdy[1];
        tick();
        if (pop1) void'(exp1_q.pop_front());
        if (pop2) void'(exp2_q.pop_front());
        if (acc) begin
            exp1_q.push_back(d);
            exp2_q.push_back(d);
        end
    endtask

    task automatic test_random();
        logic [1:0] pats [4];
        pats[0] = 2'b01;
        pats[1] = 2'b10;
        pats[2] = 2'b11;
        pats[3] = 2'b00;
        exp1_q.delete();
        exp2_q.delete();
        for (int c = 0; c < 1000; c++) begin
            random_cycle(pats[$urandom_range(0, 3)], 1'($urandom_range(0, 1)),
                         W'($urandom_range(0, 65535)), c);
        end
        for (int c = 0; c < 2 * DEPTH; c++) begin
            random_cycle(2'b11, 1'b0, W'($urandom_range(0, 65535)), 1000 + c);
        end
        n_checks++;
        if (valid_o !== 2'b00 || exp1_q.size() != 0 || exp2_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_drained: valid_o=%b q1=%0d q2=%0d, want 00 0 0",
                     valid_o, exp1_q.size(), exp2_q.size());
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 2'b00;
        data_r_i = '0;
        #12;
        test_reset();
        test_stream();
        test_lane2_stall();
        test_both_stalled();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fork_layer
